// File: rtl/spi_tx_word_framer.sv
// SPI transmit word framer: takes 32-bit (WORD_BYTES-byte) response words
// from the control logic and presents them MSB first, one byte per SPI byte
// boundary, to the byte interface. Two word slots (cur/nxt) let the producer
// queue the next word while the current one is shifting out. A mid-word end
// of frame (SS rising) drops the partial word.
module spi_tx_word_framer #(
  parameter int         WORD_BYTES = 4,
  parameter logic [7:0] IDLE_BYTE  = 8'h00
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_SS_n,
  input  logic                    i_Byte_Done,
  input  logic                    i_Word_Valid,
  input  logic [8*WORD_BYTES-1:0] i_Word,
  output logic                    o_Word_Ready,
  output logic [7:0]              o_TX_Byte,
  output logic                    o_Busy,
  output logic                    o_Underrun,
  output logic                    o_Abort,
  output logic [15:0]             o_Words_Sent
);

  localparam int W     = 8 * WORD_BYTES;
  localparam int IDX_W = (WORD_BYTES > 2) ? 2 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  typedef enum logic {EMPTY, ACTIVE} state_t;

  state_t           state, state_d;
  logic [W-1:0]     cur_word, cur_word_d;
  logic [W-1:0]     nxt_word, nxt_word_d;
  logic             nxt_valid, nxt_valid_d;
  logic             cur_valid_d;
  logic [IDX_W-1:0] byte_idx, byte_idx_d;
  logic [15:0]      words_sent_d;
  logic             underrun_d, abort_d;
  logic [W-1:0]     shifted;
  logic [7:0]       tx_byte_d;
  logic             ss_meta, ss_sync, ss_prev;
  logic             frame_end, accept;

  assign frame_end = ss_sync & ~ss_prev;
  assign accept    = i_Word_Valid & o_Word_Ready;

  // Two-flop synchroniser on slave select plus a delay flop for edge detection.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      ss_meta <= 1'b1;
      ss_sync <= 1'b1;
      ss_prev <= 1'b1;
    end else begin
      ss_meta <= i_SS_n;
      ss_sync <= ss_meta;
      ss_prev <= ss_sync;
    end
  end

  // Next-state logic: byte completion first, then frame-end abort on the
  // resulting index, then the producer's accept into whichever slot is free.
  always_comb begin
    cur_valid_d  = (state == ACTIVE);
    cur_word_d   = cur_word;
    nxt_word_d   = nxt_word;
    nxt_valid_d  = nxt_valid;
    byte_idx_d   = byte_idx;
    words_sent_d = o_Words_Sent;
    underrun_d   = 1'b0;
    abort_d      = 1'b0;

    if (i_Byte_Done) begin
      if (!cur_valid_d) begin
        underrun_d = 1'b1;
      end else if (byte_idx_d != LAST_IDX) begin
        byte_idx_d = byte_idx_d + 1'b1;
      end else begin
        words_sent_d = o_Words_Sent + 16'd1;
        byte_idx_d   = '0;
        if (nxt_valid_d) begin
          cur_word_d  = nxt_word_d;
          nxt_valid_d = 1'b0;
        end else begin
          cur_valid_d = 1'b0;
        end
      end
    end

    if (frame_end && (byte_idx_d != '0)) begin
      abort_d    = 1'b1;
      byte_idx_d = '0;
      if (nxt_valid_d) begin
        cur_word_d  = nxt_word_d;
        nxt_valid_d = 1'b0;
      end else begin
        cur_valid_d = 1'b0;
      end
    end

    if (accept) begin
      if (!cur_valid_d) begin
        cur_word_d  = i_Word;
        cur_valid_d = 1'b1;
      end else begin
        nxt_word_d  = i_Word;
        nxt_valid_d = 1'b1;
      end
    end

    state_d   = cur_valid_d ? ACTIVE : EMPTY;
    shifted   = cur_word_d << {byte_idx_d, 3'b000};
    tx_byte_d = cur_valid_d ? shifted[W-1 -: 8] : IDLE_BYTE;
  end

  // State, slot storage and all registered outputs.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state        <= EMPTY;
      cur_word     <= '0;
      nxt_word     <= '0;
      nxt_valid    <= 1'b0;
      byte_idx     <= '0;
      o_Word_Ready <= 1'b1;
      o_TX_Byte    <= IDLE_BYTE;
      o_Busy       <= 1'b0;
      o_Underrun   <= 1'b0;
      o_Abort      <= 1'b0;
      o_Words_Sent <= 16'd0;
    end else begin
      state        <= state_d;
      cur_word     <= cur_word_d;
      nxt_word     <= nxt_word_d;
      nxt_valid    <= nxt_valid_d;
      byte_idx     <= byte_idx_d;
      o_Word_Ready <= ~nxt_valid_d;
      o_TX_Byte    <= tx_byte_d;
      o_Busy       <= cur_valid_d;
      o_Underrun   <= underrun_d;
      o_Abort      <= abort_d;
      o_Words_Sent <= words_sent_d;
    end
  end

endmodule

// File: tb/tb_spi_tx_word_framer.sv
// Self-checking bench for spi_tx_word_framer: a queue of expected bytes is
// filled as words are loaded and drained as Byte_Done pulses are issued.
module tb_spi_tx_word_framer;

  localparam int WB = 4;

  logic          i_Clk;
  logic          i_Rst_L;
  logic          i_SS_n;
  logic          i_Byte_Done;
  logic          i_Word_Valid;
  logic [31:0]   i_Word;
  logic          o_Word_Ready;
  logic [7:0]    o_TX_Byte;
  logic          o_Busy;
  logic          o_Underrun;
  logic          o_Abort;
  logic [15:0]   o_Words_Sent;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_count;
  int          checks;
  int          errors;

  spi_tx_word_framer #(.WORD_BYTES(WB), .IDLE_BYTE(8'h00)) dut (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_SS_n       (i_SS_n),
    .i_Byte_Done  (i_Byte_Done),
    .i_Word_Valid (i_Word_Valid),
    .i_Word       (i_Word),
    .o_Word_Ready (o_Word_Ready),
    .o_TX_Byte    (o_TX_Byte),
    .o_Busy       (o_Busy),
    .o_Underrun   (o_Underrun),
    .o_Abort      (o_Abort),
    .o_Words_Sent (o_Words_Sent)
  );

  // 100 MHz clock.
  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] word, input logic done);
    i_Word_Valid = valid;
    i_Word       = word;
    i_Byte_Done  = done;
    tick();
    i_Word_Valid = 1'b0;
    i_Byte_Done  = 1'b0;
  endtask

  task automatic loadWord(input logic [31:0] w);
    logic [31:0] tmp;
    exp_t        e;
    for (int i = 0; i < 20 && !o_Word_Ready; i++) tick();
    checkOutput("ready_wait", 32'(o_Word_Ready), 32'd1);
    applyStimulus(1'b1, w, 1'b0);
    for (int i = 0; i < WB; i++) begin
      tmp    = w << (8 * i);
      e.b    = tmp[31:24];
      e.last = (i == WB - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulseByte();
    exp_t e;
    logic exp_under;
    exp_under = (exp_q.size() == 0);
    if (!exp_under) begin
      e = exp_q.pop_front();
      checkOutput("tx_byte", 32'(o_TX_Byte), 32'(e.b));
      if (e.last) exp_count++;
    end else begin
      checkOutput("tx_idle", 32'(o_TX_Byte), 32'h00);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("underrun", 32'(o_Underrun), 32'(exp_under));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tx"},    32'(o_TX_Byte),    32'h00);
    checkOutput({tag, "_ready"}, 32'(o_Word_Ready), 32'd1);
    checkOutput({tag, "_busy"},  32'(o_Busy),       32'd0);
    checkOutput({tag, "_under"}, 32'(o_Underrun),   32'd0);
    checkOutput({tag, "_abort"}, 32'(o_Abort),      32'd0);
    checkOutput({tag, "_count"}, 32'(o_Words_Sent), 32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    exp_count    = 16'd0;
    i_Rst_L      = 1'b0;
    i_SS_n       = 1'b0;
    i_Byte_Done  = 1'b0;
    i_Word_Valid = 1'b0;
    i_Word       = 32'h0;

    tick();
    tick();
    checkResetOutputs("reset");
    i_Rst_L = 1'b1;
    tick();
    tick();

    // Single word, MSB first, then idle.
    loadWord(32'hA1B2C3D4);
    checkOutput("t1_busy", 32'(o_Busy), 32'd1);
    for (int i = 0; i < 3; i++) pulseByte();
    checkOutput("t1_busy_last", 32'(o_Busy), 32'd1);
    pulseByte();
    checkOutput("t1_tx_idle", 32'(o_TX_Byte), 32'h00);
    checkOutput("t1_busy_fall", 32'(o_Busy), 32'd0);
    checkOutput("t1_count", 32'(o_Words_Sent), 32'(exp_count));

    // Back-to-back words through both slots.
    loadWord(32'h11223344);
    checkOutput("t2_ready1", 32'(o_Word_Ready), 32'd1);
    loadWord(32'h55667788);
    checkOutput("t2_ready2", 32'(o_Word_Ready), 32'd0);
    for (int i = 0; i < 3; i++) pulseByte();
    checkOutput("t2_ready3", 32'(o_Word_Ready), 32'd0);
    pulseByte();
    checkOutput("t2_ready4", 32'(o_Word_Ready), 32'd1);
    for (int i = 0; i < 4; i++) pulseByte();
    checkOutput("t2_tx_idle", 32'(o_TX_Byte), 32'h00);
    checkOutput("t2_count", 32'(o_Words_Sent), 32'(exp_count));

    // Underrun with nothing loaded.
    pulseByte();
    pulseByte();
    tick();
    checkOutput("t3_under_clear", 32'(o_Underrun), 32'd0);
    checkOutput("t3_count", 32'(o_Words_Sent), 32'(exp_count));

    // Mid-word abort after two bytes.
    loadWord(32'hDEADBEEF);
    pulseByte();
    pulseByte();
    i_SS_n = 1'b1;
    tick();
    tick();
    checkOutput("t4_abort_early", 32'(o_Abort), 32'd0);
    tick();
    checkOutput("t4_abort", 32'(o_Abort), 32'd1);
    checkOutput("t4_tx_idle", 32'(o_TX_Byte), 32'h00);
    checkOutput("t4_busy", 32'(o_Busy), 32'd0);
    checkOutput("t4_count", 32'(o_Words_Sent), 32'(exp_count));
    exp_q.delete();
    tick();
    checkOutput("t4_abort_clear", 32'(o_Abort), 32'd0);
    i_SS_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    loadWord(32'h12345678);
    for (int i = 0; i < 4; i++) pulseByte();
    checkOutput("t4_count_after", 32'(o_Words_Sent), 32'(exp_count));

    // Last Byte_Done coincides with frame end; next word pending.
    loadWord(32'h01020304);
    loadWord(32'hCAFE0001);
    for (int i = 0; i < 3; i++) pulseByte();
    i_SS_n = 1'b1;
    tick();
    tick();
    pulseByte();
    checkOutput("t5_abort", 32'(o_Abort), 32'd0);
    checkOutput("t5_tx", 32'(o_TX_Byte), 32'hCA);
    checkOutput("t5_count", 32'(o_Words_Sent), 32'(exp_count));
    i_SS_n = 1'b0;
    tick();
    checkOutput("t5_abort_later", 32'(o_Abort), 32'd0);
    tick();
    tick();
    for (int i = 0; i < 4; i++) pulseByte();
    checkOutput("t5_count_after", 32'(o_Words_Sent), 32'(exp_count));

    // Counter wrap from 0xFFFF.
    force dut.o_Words_Sent = 16'hFFFF;
    tick();
    release dut.o_Words_Sent;
    exp_count = 16'hFFFF;
    loadWord(32'h0F1E2D3C);
    for (int i = 0; i < 4; i++) pulseByte();
    checkOutput("t6_wrap", 32'(o_Words_Sent), 32'h0000);

    // Reset in the middle of a word.
    loadWord(32'h89ABCDEF);
    loadWord(32'h13579BDF);
    pulseByte();
    i_Rst_L = 1'b0;
    tick();
    checkResetOutputs("midrst");
    i_Rst_L = 1'b1;
    exp_q.delete();
    exp_count = 16'd0;
    tick();
    pulseByte();
    checkOutput("midrst_count", 32'(o_Words_Sent), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_tx_word_framer.md
Name: spi_tx_word_framer

Overview:
Transmit-side partner of the SPI receive path. The receive path packs four rxValid bytes, MSB first, into a 32-bit command word. This block does the reverse: it accepts 32-bit response/readback words (status, sample count, memory readback) from the control logic. It splits each word into bytes, MSB first, and drives the byte-interface tx input, advancing one byte per byte-boundary pulse. It sits between the control FSM and the SPI byte interface in the 100 MHz system domain.

Parameters:
WORD_BYTES, 4, bytes per word; valid range 2..4.
IDLE_BYTE, 8'h00, byte driven when no word is loaded.

Ports:
i_Clk  in  1  system clock (100 MHz domain).
i_Rst_L  in  1  reset, synchronous, active-low.
i_SS_n  in  1  raw SPI slave select, active-low, asynchronous; 2-FF synchronised internally.
i_Byte_Done  in  1  one-cycle pulse per completed SPI byte (the byte interface rxValid).
i_Word_Valid  in  1  producer has a word on i_Word.
i_Word  in  8*WORD_BYTES  word to transmit.
o_Word_Ready  out  1  block can accept a word this cycle.
o_TX_Byte  out  8  byte to the byte interface tx input.
o_Busy  out  1  a word is loaded (cur slot valid).
o_Underrun  out  1  one-cycle pulse: i_Byte_Done with no word loaded.
o_Abort  out  1  one-cycle pulse: frame ended mid-word.
o_Words_Sent  out  16  count of fully transmitted words.

Behaviour:
- Reset, while i_Rst_L=0 at a clock edge:
  - o_TX_Byte=IDLE_BYTE, o_Word_Ready=1, o_Busy=0, o_Underrun=0, o_Abort=0, o_Words_Sent=0.
  - Both slots empty, byte_idx=0, SS sync flops=1.
  - Reset mid-word discards all buffered data.
- Storage is two slots: cur (being shifted) and nxt (pending). o_Word_Ready = !nxt_valid, registered.
- Accept on i_Word_Valid && o_Word_Ready at the clock edge.
  - The word goes to cur if cur is empty, or if cur completes in the same cycle and nxt is empty.
  - Otherwise it goes to nxt.
- FSM states:
  - EMPTY: cur invalid. Byte_Done -> o_Underrun pulse, stay in EMPTY. Accept -> ACTIVE.
  - ACTIVE: cur valid; o_TX_Byte = cur byte[byte_idx]. idx0 = bits [8*WORD_BYTES-1 -: 8].
    - Byte_Done with byte_idx < WORD_BYTES-1: byte_idx+1.
    - Byte_Done with byte_idx = WORD_BYTES-1: o_Words_Sent+1 (wraps 0xFFFF->0), byte_idx=0. cur <= nxt if nxt is valid (stay ACTIVE), else go to EMPTY.
- o_TX_Byte is registered. It reflects a new state exactly 1 cycle after the causing edge (accept, Byte_Done, abort).
- Frame end is the synchronised rising edge of i_SS_n, detected 3 cycles after the pin edge.
  - If byte_idx != 0: discard cur, byte_idx=0, promote nxt (or go to EMPTY), pulse o_Abort. o_Words_Sent is unchanged.
  - If byte_idx = 0: no change; complete words are never dropped.
- Byte_Done and frame end in the same cycle: apply Byte_Done first, then evaluate abort on the resulting byte_idx.
  - Example: the last byte completes and the SS edge arrives together -> word counted, no abort.
- An accept in the same cycle as an abort is retained, following the slot rules applied after the discard.
- o_Busy = cur_valid, registered alongside o_TX_Byte.

Test Plan:
- Reset then load 32'hA1B2C3D4 with SS low and 4 Byte_Done pulses -> o_TX_Byte sequence A1,B2,C3,D4, then 00. o_Words_Sent=1, o_Busy falls 1 cycle after the 4th pulse.
- Back-to-back: load 32'h11223344 and 32'h55667788 on consecutive cycles, then 8 pulses -> o_Word_Ready=0 after the 2nd accept until the 4th pulse. Bytes 11..44 then 55..88 with no gap; count=2.
- Underrun: 2 Byte_Done pulses with nothing loaded -> two o_Underrun pulses, o_TX_Byte=00 throughout, count=0.
- Mid-word abort: load 32'hDEADBEEF, 2 pulses (DE, AD), raise i_SS_n -> o_Abort pulses 3 cycles later, o_TX_Byte=00, count unchanged. A following load starts at its MSB.
- Simultaneous last Byte_Done and SS rise, with nxt=32'hCAFE0001 -> no abort, count+1, o_TX_Byte=CA next cycle.
- Count wrap: preset o_Words_Sent to 16'hFFFF via 65535 words (or a force), send one word -> 16'h0000. Also assert i_Rst_L=0 mid-word -> all outputs return to reset values on the next edge.
